// File: rtl/subsystem_led_pkg.sv
// Shared types for the multi-channel LED subsystem: FSM states, channel modes, width helper.
package subsystem_led_pkg;

    typedef enum logic [1:0] {
        ST_TEST_ALL  = 2'd0,
        ST_TEST_EACH = 2'd1,
        ST_RUN       = 2'd2
    } led_state_t;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_SLOW    = 2'b01,
        MODE_FAST    = 2'b10,
        MODE_STRETCH = 2'b11
    } led_mode_t;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode selection, blink gating and pulse stretching.
module led_channel
    import subsystem_led_pkg::*;
#(
    parameter int unsigned STRETCH = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_led_in,
    input  logic [1:0] i_mode,
    input  logic       i_slow_phase,
    input  logic       i_fast_phase,
    output logic       o_active_c
);

    localparam int unsigned CW = cnt_width(STRETCH + 1);

    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_rise;

    assign w_rise = i_led_in & ~r_prev;

    // Stretch counter: reload on a rising edge, otherwise count down to zero and hold.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_rise) begin
            w_cnt_next = CW'(STRETCH);
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CW'(1);
        end
    end

    // Edge sampler and stretch counter run in every mode and every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_led_in;
            r_cnt  <= w_cnt_next;
        end
    end

    // Mode-dependent activity; stretch uses the post-update count so a
    // single-cycle pulse lasts exactly STRETCH cycles.
    always_comb begin
        o_active_c = 1'b0;
        case (i_mode)
            MODE_DIRECT:  o_active_c = i_led_in;
            MODE_SLOW:    o_active_c = i_led_in & i_slow_phase;
            MODE_FAST:    o_active_c = i_led_in & i_fast_phase;
            MODE_STRETCH: o_active_c = i_led_in | (w_cnt_next != '0);
            default:      o_active_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/subsystem_led_multi.sv
// Multi-channel LED driver: power-on self-test sequence, blink/PWM timebases, per-channel gating.
module subsystem_led_multi
    import subsystem_led_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 125000000,
    parameter int unsigned NUM_LED     = 4,
    parameter int unsigned INVERTED    = 0,
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned STRETCH_DIV = 20,
    parameter int unsigned PWM_BITS    = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LED-1:0]    led_in,
    input  logic [2*NUM_LED-1:0]  led_mode,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  test_req,
    output logic [NUM_LED-1:0]    led_out,
    output logic                  ready
);

    localparam int unsigned STEP      = CLK_FREQ / STEP_DIV;
    localparam int unsigned STRETCH   = CLK_FREQ / STRETCH_DIV;
    localparam int unsigned SLOW_HALF = CLK_FREQ / 2;
    localparam int unsigned FAST_HALF = CLK_FREQ / 8;
    localparam int unsigned STEP_W    = cnt_width(STEP);
    localparam int unsigned CH_W      = cnt_width(NUM_LED);
    localparam int unsigned SLOW_W    = cnt_width(SLOW_HALF);
    localparam int unsigned FAST_W    = cnt_width(FAST_HALF);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_LED - 1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);
    localparam logic [FAST_W-1:0] FAST_LAST = FAST_W'(FAST_HALF - 1);
    localparam logic              POL       = (INVERTED != 0);

    led_state_t          r_state;
    logic [STEP_W-1:0]   r_step;
    logic [CH_W-1:0]     r_ch;
    logic [SLOW_W-1:0]   r_slow_cnt;
    logic [FAST_W-1:0]   r_fast_cnt;
    logic                r_slow_ph;
    logic                r_fast_ph;
    logic [PWM_BITS-1:0] r_pwm;
    logic [NUM_LED-1:0]  w_active;
    logic [NUM_LED-1:0]  w_on;
    logic                w_pwm_pass;

    // Per-channel mode, blink and stretch logic.
    for (genvar n = 0; n < NUM_LED; n++) begin : g_ch
        led_channel #(
            .STRETCH (STRETCH)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_led_in     (led_in[n]),
            .i_mode       (led_mode[2*n +: 2]),
            .i_slow_phase (r_slow_ph),
            .i_fast_phase (r_fast_ph),
            .o_active_c   (w_active[n])
        );
    end

    // Free-running blink phases and PWM counter, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slow_cnt <= '0;
            r_fast_cnt <= '0;
            r_slow_ph  <= 1'b0;
            r_fast_ph  <= 1'b0;
            r_pwm      <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_BITS'(1);
            if (r_slow_cnt == SLOW_LAST) begin
                r_slow_cnt <= '0;
                r_slow_ph  <= ~r_slow_ph;
            end else begin
                r_slow_cnt <= r_slow_cnt + SLOW_W'(1);
            end
            if (r_fast_cnt == FAST_LAST) begin
                r_fast_cnt <= '0;
                r_fast_ph  <= ~r_fast_ph;
            end else begin
                r_fast_cnt <= r_fast_cnt + FAST_W'(1);
            end
        end
    end

    // Full brightness passes activity untouched; zero brightness never passes.
    assign w_pwm_pass = (brightness == '1) || (r_pwm < brightness);

    // Self-test states force full-on drive; RUN uses gated channel activity.
    always_comb begin
        w_on = '0;
        case (r_state)
            ST_TEST_ALL:  w_on = '1;
            ST_TEST_EACH: w_on = NUM_LED'(1) << r_ch;
            ST_RUN:       w_on = w_pwm_pass ? w_active : '0;
            default:      w_on = '0;
        endcase
    end

    // Sequencer FSM with registered pad drive and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_TEST_ALL;
            r_step  <= '0;
            r_ch    <= '0;
            led_out <= {NUM_LED{POL}};
            ready   <= 1'b0;
        end else begin
            led_out <= w_on ^ {NUM_LED{POL}};
            ready   <= (r_state == ST_RUN);
            case (r_state)
                ST_TEST_ALL: begin
                    if (r_step == STEP_LAST) begin
                        r_state <= ST_TEST_EACH;
                        r_step  <= '0;
                        r_ch    <= '0;
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                ST_TEST_EACH: begin
                    if (r_step == STEP_LAST) begin
                        r_step <= '0;
                        if (r_ch == CH_LAST) begin
                            r_state <= ST_RUN;
                            r_ch    <= '0;
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end else begin
                        r_step <= r_step + STEP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (test_req) begin
                        r_state <= ST_TEST_ALL;
                        r_step  <= '0;
                        r_ch    <= '0;
                    end
                end
                default: begin
                    r_state <= ST_TEST_ALL;
                    r_step  <= '0;
                    r_ch    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subsystem_led_multi.sv
// Self-checking bench for subsystem_led_multi: directed table, hand sequences, randomized model check.
module tb_subsystem_led_multi;

    localparam int STEP     = 16;
    localparam int TEST_LEN = 80;
    localparam int STRETCH  = 8;
    localparam int SLOW_H   = 32;
    localparam int FAST_H   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] led_in = '0;
    logic [7:0] led_mode = '0;
    logic [3:0] brightness = 4'hF;
    logic       test_req = 1'b0;
    logic [3:0] led_out, led_out_inv;
    logic       ready, ready_inv;

    always #5 clk = ~clk;

    subsystem_led_multi #(
        .CLK_FREQ(64), .NUM_LED(4), .INVERTED(0), .STEP_DIV(4), .STRETCH_DIV(8), .PWM_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .led_mode(led_mode), .brightness(brightness),
        .test_req(test_req), .led_out(led_out), .ready(ready)
    );

    subsystem_led_multi #(
        .CLK_FREQ(64), .NUM_LED(4), .INVERTED(1), .STEP_DIV(4), .STRETCH_DIV(8), .PWM_BITS(4)
    ) dut_inv (
        .clk(clk), .rst(rst), .led_in(led_in), .led_mode(led_mode), .brightness(brightness),
        .test_req(test_req), .led_out(led_out_inv), .ready(ready_inv)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since reset release, start of current self-test, last rising edges.
    int         k = 0;
    int         s = 0;
    int         t_rise [4];
    logic [3:0] prev_in = '0;
    logic [3:0] exp_out = '0;
    logic       exp_ready = 1'b0;

    typedef struct {
        logic [3:0] vin;
        logic [3:0] br;
        logic [3:0] vexp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, k);
        end
    endtask

    // Expected outputs after the coming clock edge, from the current inputs.
    task automatic model_edge();
        int   d;
        logic act;
        if (rst) begin
            k = 0;
            s = 0;
            prev_in = '0;
            for (int i = 0; i < 4; i++) t_rise[i] = -1000;
            exp_out = 4'h0;
            exp_ready = 1'b0;
        end else begin
            d = k - s;
            for (int i = 0; i < 4; i++) begin
                if (led_in[i] && !prev_in[i]) t_rise[i] = k;
            end
            prev_in = led_in;
            if (d < STEP) begin
                exp_out = 4'hF;
            end else if (d < TEST_LEN) begin
                exp_out = 4'(1 << ((d - STEP) / STEP));
            end else begin
                for (int i = 0; i < 4; i++) begin
                    case (led_mode[2*i +: 2])
                        2'b00:   act = led_in[i];
                        2'b01:   act = led_in[i] && (((k / SLOW_H) % 2) == 1);
                        2'b10:   act = led_in[i] && (((k / FAST_H) % 2) == 1);
                        default: act = led_in[i] || ((k - t_rise[i]) < STRETCH);
                    endcase
                    exp_out[i] = act && ((brightness == 4'hF) || ((k % 16) < int'(brightness)));
                end
            end
            exp_ready = (d >= TEST_LEN);
            if (d >= TEST_LEN && test_req) s = k + 1;
            k++;
        end
    endtask

    // One clock: predict, advance, compare both polarities.
    task automatic cycle();
        logic [3:0] exp_inv;
        model_edge();
        @(posedge clk);
        #1;
        exp_inv = ~exp_out;
        check("led_out", led_out, exp_out);
        check("led_out_inv", led_out_inv, exp_inv);
        check("ready", ready, exp_ready);
        check("ready_inv", ready_inv, exp_ready);
    endtask

    initial begin
        vec_t vt [6];
        int   hi;
        int   cnt [4];
        int   last, gap;
        logic prv;
        int   waited;

        vt[0] = '{vin: 4'b0101, br: 4'hF, vexp: 4'b0101};
        vt[1] = '{vin: 4'b1010, br: 4'hF, vexp: 4'b1010};
        vt[2] = '{vin: 4'b1111, br: 4'hF, vexp: 4'b1111};
        vt[3] = '{vin: 4'b0000, br: 4'hF, vexp: 4'b0000};
        vt[4] = '{vin: 4'b1111, br: 4'h0, vexp: 4'b0000};
        vt[5] = '{vin: 4'b1001, br: 4'hF, vexp: 4'b1001};

        // Reset and the power-on self-test sequence.
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (TEST_LEN) cycle();
        cycle();
        check("ready_at_80", ready, 1'b1);

        // Direct mode table.
        led_mode = 8'h00;
        for (int i = 0; i < 6; i++) begin
            led_in = vt[i].vin;
            brightness = vt[i].br;
            cycle();
            check("vec_table", led_out, vt[i].vexp);
        end

        // Pulse stretch on ch0: single pulse, then two pulses four cycles apart.
        led_mode = 8'b0000_0011;
        brightness = 4'hF;
        led_in = 4'h0;
        repeat (10) cycle();
        hi = 0;
        for (int j = 0; j < 20; j++) begin
            led_in[0] = (j == 0);
            cycle();
            hi += int'(led_out[0]);
        end
        check("stretch_single", hi, 8);
        hi = 0;
        for (int j = 0; j < 24; j++) begin
            led_in[0] = (j == 0) || (j == 4);
            cycle();
            hi += int'(led_out[0]);
        end
        check("stretch_double", hi, 12);

        // PWM duty at brightness 4, then brightness 0.
        led_mode = 8'h00;
        led_in = 4'hF;
        brightness = 4'h4;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int j = 0; j < 16; j++) begin
            cycle();
            for (int i = 0; i < 4; i++) cnt[i] += int'(led_out[i]);
        end
        for (int i = 0; i < 4; i++) check("pwm_duty4", cnt[i], 4);
        brightness = 4'h0;
        hi = 0;
        for (int j = 0; j < 16; j++) begin
            cycle();
            hi += int'(led_out != 4'h0);
        end
        check("pwm_zero", hi, 0);

        // Blink periods on ch1: slow then fast.
        brightness = 4'hF;
        led_in = 4'b0010;
        led_mode = 8'b0000_0100;
        last = -1; gap = -1; prv = led_out[1];
        for (int j = 0; j < 100; j++) begin
            cycle();
            if (led_out[1] !== prv) begin
                if (last >= 0) gap = j - last;
                last = j;
                prv = led_out[1];
            end
        end
        check("slow_period", gap, SLOW_H);
        led_mode = 8'b0000_1000;
        last = -1; gap = -1; prv = led_out[1];
        for (int j = 0; j < 40; j++) begin
            cycle();
            if (led_out[1] !== prv) begin
                if (last >= 0) gap = j - last;
                last = j;
                prv = led_out[1];
            end
        end
        check("fast_period", gap, FAST_H);

        // Rerun self-test from RUN; a request during the test must not restart it.
        led_mode = 8'h00;
        led_in = 4'h0;
        test_req = 1'b1;
        cycle();
        test_req = 1'b0;
        cycle();
        check("retest_ready_low", ready, 1'b0);
        check("retest_all_on", led_out, 4'hF);
        waited = 1;
        while (ready !== 1'b1 && waited < 200) begin
            test_req = (waited == 30);
            cycle();
            waited++;
        end
        test_req = 1'b0;
        check("retest_length", waited, TEST_LEN + 1);

        // Randomized traffic against the model, with occasional test requests and resets.
        for (int j = 0; j < 3000; j++) begin
            led_in = 4'($urandom);
            if ($urandom_range(15) == 0) led_mode = 8'($urandom);
            if ($urandom_range(31) == 0) brightness = 4'($urandom);
            test_req = ($urandom_range(199) == 0);
            rst = ($urandom_range(599) == 0);
            cycle();
        end
        rst = 1'b0;
        test_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
